// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the receiver state encoding, default frame constants and the parity check.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Data is zero-extended to 9 bits; the padding does not change the XOR.
  function automatic logic parity_mismatch(input logic [8:0] data,
                                           input logic       sampled,
                                           input logic       odd);
    return ((^data) ^ sampled) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer for the asynchronous rx line.
// Resets to 1 so that an idle (high) line is seen immediately after reset.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) ff <= '1;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling, optional parity,
// registered one-cycle valid / parity-error / framing-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy,
  output rx_state_t            state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_next;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err_q;
  logic                 start_sample;
  logic                 bit_sample;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (rx_in),
    .q      (rx_s)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_s) state_next = START;
      START:   if (start_sample) state_next = rx_s ? IDLE : DATA;
      DATA:    if (bit_sample && bit_cnt == LAST_BIT)
                 state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_sample) state_next = STOP;
      STOP:    if (bit_sample) state_next = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Start is checked half a bit in; every later bit a full bit period after that.
  always_comb begin
    start_sample = (state == START) && baud_tick && (tick_cnt == HALF_TICK);
    bit_sample   = ((state == DATA) || (state == PARITY) || (state == STOP))
                   && baud_tick && (tick_cnt == LAST_TICK);
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_err_q   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;

      if (state_next != state)
        tick_cnt <= '0;
      else if (baud_tick)
        tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;

      if (state == START) begin
        bit_cnt   <= '0;
        par_err_q <= 1'b0;
      end

      if (state == DATA && bit_sample) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == PARITY && bit_sample)
        par_err_q <= parity_mismatch(9'(shift), rx_s, PARITY_ODD != 0);

      if (state == STOP && bit_sample) begin
        rx_data <= shift;
        if (rx_s) begin
          rx_valid   <= 1'b1;
          parity_err <= par_err_q;
        end else begin
          framing_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance share clock, tick and reset.
// Expected frames go into per-instance queues; monitors pop and compare on each strobe.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = UART_OVERSAMPLE * 4;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       rx_n, rx_p;
  logic [7:0] d_n, d_p;
  logic       v_n, pe_n, fe_n, busy_n;
  logic       v_p, pe_p, fe_p, busy_p;
  rx_state_t  st_n, st_p;

  int total = 0;
  int bad   = 0;

  // {framing_err, parity_err, rx_data}
  logic [9:0] exp_n_q[$];
  logic [9:0] exp_p_q[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_n (
    .clk_in(clk_in), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_n),
    .rx_data(d_n), .rx_valid(v_n), .parity_err(pe_n), .framing_err(fe_n),
    .busy(busy_n), .state(st_n)
  );

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_p (
    .clk_in(clk_in), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_p),
    .rx_data(d_p), .rx_valid(v_p), .parity_err(pe_p), .framing_err(fe_p),
    .busy(busy_p), .state(st_p)
  );

  // ---------------- clock / tick ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    baud_tick = 1'b0;
    forever begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk_in);
        baud_tick = (i == 3);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input bit to_p, input logic b);
    @(negedge clk_in);
    if (to_p) rx_p = b;
    else      rx_n = b;
    repeat (BIT_CLKS - 1) @(negedge clk_in);
  endtask

  task automatic send_frame(input bit to_p, input logic [7:0] data, input bit par_en,
                            input logic par_bit, input logic stop_bit);
    drive_bit(to_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_p, data[i]);
    if (par_en) drive_bit(to_p, par_bit);
    drive_bit(to_p, stop_bit);
  endtask

  // ---------------- monitors / scoreboard ----------------
  initial begin : mon_n
    logic [9:0] e;
    forever begin
      @(negedge clk_in);
      if (v_n || pe_n || fe_n) begin
        if (exp_n_q.size() == 0) begin
          check("n_unexpected_strobe", {29'd0, v_n, pe_n, fe_n}, 32'd0);
        end else begin
          e = exp_n_q.pop_front();
          check("n_rx_data", {24'd0, d_n}, {24'd0, e[7:0]});
          check("n_flags_fe_pe_v", {29'd0, fe_n, pe_n, v_n}, {29'd0, e[9], e[8], ~e[9]});
          check("n_busy_at_strobe", {31'd0, busy_n}, {31'd0, e[9]});
        end
        @(negedge clk_in);
        check("n_pulse_width", {29'd0, v_n, pe_n, fe_n}, 32'd0);
      end
    end
  end

  initial begin : mon_p
    logic [9:0] e;
    forever begin
      @(negedge clk_in);
      if (v_p || pe_p || fe_p) begin
        if (exp_p_q.size() == 0) begin
          check("p_unexpected_strobe", {29'd0, v_p, pe_p, fe_p}, 32'd0);
        end else begin
          e = exp_p_q.pop_front();
          check("p_rx_data", {24'd0, d_p}, {24'd0, e[7:0]});
          check("p_flags_fe_pe_v", {29'd0, fe_p, pe_p, v_p}, {29'd0, e[9], e[8], ~e[9]});
          check("p_busy_at_strobe", {31'd0, busy_p}, {31'd0, e[9]});
        end
        @(negedge clk_in);
        check("p_pulse_width", {29'd0, v_p, pe_p, fe_p}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] part;
    reset = 1'b1;
    rx_n  = 1'b1;
    rx_p  = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset_n_outputs", {20'd0, d_n, v_n, pe_n, fe_n, busy_n}, 32'd0);
    check("reset_p_outputs", {20'd0, d_p, v_p, pe_p, fe_p, busy_p}, 32'd0);
    check("reset_n_state", {29'd0, st_n}, {29'd0, IDLE});
    reset = 1'b0;
    repeat (10) @(negedge clk_in);

    // 1: 0xA5 8N1
    exp_n_q.push_back({2'b00, 8'hA5});
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk_in);

    // 2: 3-tick glitch on the line
    @(negedge clk_in);
    rx_n = 1'b0;
    repeat (8) @(negedge clk_in);
    check("glitch_busy_high", {31'd0, busy_n}, 32'd1);
    repeat (4) @(negedge clk_in);
    rx_n = 1'b1;
    repeat (40) @(negedge clk_in);
    check("glitch_busy_low", {31'd0, busy_n}, 32'd0);
    check("glitch_data_kept", {24'd0, d_n}, 32'hA5);

    // 3: 0x3C with bad stop bit, line held low
    exp_n_q.push_back({2'b10, 8'h3C});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40 * 4) @(negedge clk_in);
    check("break_busy_high", {31'd0, busy_n}, 32'd1);
    check("break_data", {24'd0, d_n}, 32'h3C);
    rx_n = 1'b1;
    repeat (8) @(negedge clk_in);
    check("break_busy_low", {31'd0, busy_n}, 32'd0);
    repeat (BIT_CLKS) @(negedge clk_in);

    // 4: even parity; 0x07 has three ones so parity bit 1 is correct
    exp_p_q.push_back({2'b01, 8'h07});
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    exp_p_q.push_back({2'b00, 8'h07});
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    exp_p_q.push_back({2'b00, 8'h03});
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    exp_p_q.push_back({2'b01, 8'h03});
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    repeat (BIT_CLKS) @(negedge clk_in);

    // 5: back-to-back frames
    exp_n_q.push_back({2'b00, 8'h00});
    exp_n_q.push_back({2'b00, 8'hFF});
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk_in);

    // 6: reset in the middle of data bit 4 of 0x5A
    part = 8'h5A;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, part[i]);
    @(negedge clk_in);
    rx_n = part[4];
    repeat (32) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    check("midreset_n_outputs", {20'd0, d_n, v_n, pe_n, fe_n, busy_n}, 32'd0);
    check("midreset_p_outputs", {20'd0, d_p, v_p, pe_p, fe_p, busy_p}, 32'd0);
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    rx_n  = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_in);
    exp_n_q.push_back({2'b00, 8'hC3});
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk_in);
    check("final_data", {24'd0, d_n}, 32'hC3);

    for (int i = 0; i < 200 && (exp_n_q.size() != 0 || exp_p_q.size() != 0); i++)
      @(negedge clk_in);
    check("n_queue_drained", exp_n_q.size(), 32'd0);
    check("p_queue_drained", exp_p_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
